// File: rtl/instrumented_adder_pkg.sv
// Shared constants for the instrumented Brent-Kung adder wrapper: widths,
// register addresses and bit positions on the LA2 control word and GPIO bus.
package instrumented_adder_pkg;

  localparam int WIDTH   = 32;
  localparam int IO_BITS = 38;

  localparam logic [2:0] ADDR_A    = 3'd0;
  localparam logic [2:0] ADDR_B    = 3'd1;
  localparam logic [2:0] ADDR_EXT  = 3'd2;
  localparam logic [2:0] ADDR_RING = 3'd3;
  localparam logic [2:0] ADDR_SSEL = 3'd4;

  localparam int LA2_ADDR_LSB = 0;
  localparam int LA2_ADDR_MSB = 2;
  localparam int LA2_WR_BIT   = 3;
  localparam int LA2_RUN_BIT  = 4;
  localparam int LA2_CLR_BIT  = 5;

  localparam int IO_CHAIN_BIT = 8;
  localparam int IO_EXT_BIT   = 9;
  localparam int IO_RUN_BIT   = 10;

endpackage

// File: rtl/instrumented_adder_brent_wrap_adder.sv
// Combinational 32-bit Brent-Kung adder: up-sweep builds power-of-two group
// generates, down-sweep fills in the remaining prefixes; carry-in 0.
module brent_kung_adder32
  import instrumented_adder_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  localparam int UP_STAGES = 5;
  localparam int STAGES    = 2 * UP_STAGES - 1;

  genvar gi, gj;
  generate
    for (gi = 0; gi <= STAGES; gi++) begin : stg
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      if (gi == 0) begin : g_init
        assign g = a & b;
        assign p = a ^ b;
      end else begin : g_tree
        // Up-sweep distances 1,2,4,8,16 then down-sweep 8,4,2,1.
        localparam int L = (gi <= UP_STAGES) ? gi - 1 : 2 * UP_STAGES - 1 - gi;
        localparam int D = 1 << L;
        for (gj = 0; gj < WIDTH; gj++) begin : bit_g
          localparam bit COMB = (gi <= UP_STAGES) ?
                                (((gj + 1) % (2 * D)) == 0) :
                                ((((gj + 1) % (2 * D)) == D) && ((gj + 1) > 2 * D));
          if (COMB) begin : g_op
            assign g[gj] = stg[gi-1].g[gj] | (stg[gi-1].p[gj] & stg[gi-1].g[gj-D]);
            assign p[gj] = stg[gi-1].p[gj] & stg[gi-1].p[gj-D];
          end else begin : g_pass
            assign g[gj] = stg[gi-1].g[gj];
            assign p[gj] = stg[gi-1].p[gj];
          end
        end
      end
    end
  endgenerate

  // Final prefix g[i] is the carry into bit i+1; the top carry is discarded.
  assign sum = stg[0].p ^ {stg[STAGES].g[WIDTH-2:0], 1'b0};

  logic unused_prefix;
  assign unused_prefix = stg[STAGES].g[WIDTH-1] ^ (^stg[STAGES].p);

endmodule

// File: rtl/instrumented_adder_brent_wrap.sv
// Caravel wrapper: LA-loaded operands/masks, a registered sum->A feedback ring
// and an optional toggle counter (enabled by defining EDGE_COUNTER_EN).
module instrumented_adder_brent_wrap
  import instrumented_adder_pkg::*;
(
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  input  logic               active,
  input  logic [WIDTH-1:0]   la1_data_in,
  output logic [WIDTH-1:0]   la1_data_out,
  input  logic [WIDTH-1:0]   la1_oenb,
  input  logic [WIDTH-1:0]   la2_data_in,
  output logic [WIDTH-1:0]   la2_data_out,
  input  logic [WIDTH-1:0]   la2_oenb,
  input  logic [WIDTH-1:0]   la3_data_in,
  output logic [WIDTH-1:0]   la3_data_out,
  input  logic [WIDTH-1:0]   la3_oenb,
  input  logic [IO_BITS-1:0] io_in,
  output logic [IO_BITS-1:0] io_out,
  output logic [IO_BITS-1:0] io_oeb
);

  logic [WIDTH-1:0] a_input_reg, b_input_reg, a_ext_mask_reg, a_ring_mask_reg, s_sel_mask_reg;
  logic             chain_out_reg, strobe_q_reg;
  logic [2:0]       addr;
  logic             wr_pulse, run, chain_next;
  logic [WIDTH-1:0] a_eff, sum, rdata, count_val;
  logic [IO_BITS-1:0] io_out_act, io_oeb_act;

  assign addr     = la2_data_in[LA2_ADDR_MSB:LA2_ADDR_LSB];
  assign run      = la2_data_in[LA2_RUN_BIT];
  assign wr_pulse = la2_data_in[LA2_WR_BIT] & ~strobe_q_reg;

  // Ext bits win over ring bits where both masks are set.
  assign a_eff = (a_input_reg & ~(a_ext_mask_reg | a_ring_mask_reg))
               | (io_in[IO_EXT_BIT] ? a_ext_mask_reg : '0)
               | (chain_out_reg ? '0 : (a_ring_mask_reg & ~a_ext_mask_reg));

  brent_kung_adder32 u_adder (
    .a   (a_eff),
    .b   (b_input_reg),
    .sum (sum)
  );

  assign chain_next = |(sum & s_sel_mask_reg);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      a_input_reg     <= '0;
      b_input_reg     <= '0;
      a_ext_mask_reg  <= '0;
      a_ring_mask_reg <= '0;
      s_sel_mask_reg  <= '0;
      chain_out_reg   <= 1'b0;
      strobe_q_reg    <= 1'b0;
    end else begin
      strobe_q_reg <= la2_data_in[LA2_WR_BIT];
      if (wr_pulse) begin
        case (addr)
          ADDR_A:    a_input_reg     <= la1_data_in;
          ADDR_B:    b_input_reg     <= la1_data_in;
          ADDR_EXT:  a_ext_mask_reg  <= la1_data_in;
          ADDR_RING: a_ring_mask_reg <= la1_data_in;
          ADDR_SSEL: s_sel_mask_reg  <= la1_data_in;
          default:   ;
        endcase
      end
      if (run) chain_out_reg <= chain_next;
    end
  end

`ifdef EDGE_COUNTER_EN
  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      count_reg <= '0;
    end else if (la2_data_in[LA2_CLR_BIT]) begin
      count_reg <= '0;
    end else if (run && (chain_next != chain_out_reg)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count_val = count_reg;
`else
  logic unused_clr;
  assign unused_clr = la2_data_in[LA2_CLR_BIT];
  assign count_val  = '0;
`endif

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_A:    rdata = a_input_reg;
      ADDR_B:    rdata = b_input_reg;
      ADDR_EXT:  rdata = a_ext_mask_reg;
      ADDR_RING: rdata = a_ring_mask_reg;
      ADDR_SSEL: rdata = s_sel_mask_reg;
      default:   rdata = '0;
    endcase
  end

  always_comb begin
    io_out_act               = '0;
    io_out_act[IO_CHAIN_BIT] = chain_out_reg;
    io_out_act[IO_RUN_BIT]   = run;
    io_oeb_act               = '1;
    io_oeb_act[IO_CHAIN_BIT] = 1'b0;
    io_oeb_act[IO_RUN_BIT]   = 1'b0;
  end

  assign la1_data_out = active ? sum       : '0;
  assign la2_data_out = active ? count_val : '0;
  assign la3_data_out = active ? rdata     : '0;
  assign io_out       = active ? io_out_act : '0;
  assign io_oeb       = active ? io_oeb_act : '1;

  logic unused_inputs;
  assign unused_inputs = ^{la1_oenb, la2_oenb, la3_data_in, la3_oenb,
                           io_in[IO_BITS-1:IO_EXT_BIT+1], io_in[IO_EXT_BIT-1:0],
                           la2_data_in[WIDTH-1:LA2_CLR_BIT+1]};

endmodule

// File: tb/tb_instrumented_adder_brent_wrap.sv
// Scoreboard bench for instrumented_adder_brent_wrap; counter checks adapt to
// whether EDGE_COUNTER_EN is defined for the build.
module tb_instrumented_adder_brent_wrap;
  import instrumented_adder_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               active;
  logic [31:0]        la1_data_in, la1_data_out, la2_data_in, la2_data_out, la3_data_out;
  logic [IO_BITS-1:0] io_in, io_out, io_oeb;
  logic [2:0]         addr_v;
  logic               strobe_v, run_v, clr_v, ext_v;

  always #5 clk = ~clk;

  assign la2_data_in = {26'd0, clr_v, run_v, strobe_v, addr_v};
  assign io_in       = {28'd0, ext_v, 9'd0};

  instrumented_adder_brent_wrap dut (
    .wb_clk_i     (clk),
    .wb_rst_n     (rst_n),
    .active       (active),
    .la1_data_in  (la1_data_in),
    .la1_data_out (la1_data_out),
    .la1_oenb     (32'hFFFF_FFFF),
    .la2_data_in  (la2_data_in),
    .la2_data_out (la2_data_out),
    .la2_oenb     (32'hFFFF_FFFF),
    .la3_data_in  (32'd0),
    .la3_data_out (la3_data_out),
    .la3_oenb     (32'hFFFF_FFFF),
    .io_in        (io_in),
    .io_out       (io_out),
    .io_oeb       (io_oeb)
  );

  typedef struct {
    string       tag;
    logic [37:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          compared   = 0;
  int          mismatched = 0;
  logic        model_chain;
  logic [31:0] model_count;
  logic [IO_BITS-1:0] oeb_all1, oeb_act;

`ifdef EDGE_COUNTER_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_v = a; la1_data_in = d; strobe_v = 1'b1;
    @(negedge clk);
    strobe_v = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; active = 1'b0; la1_data_in = '0; addr_v = '0;
    strobe_v = 1'b0; run_v = 1'b0; clr_v = 1'b0; ext_v = 1'b0;
    repeat (2) @(negedge clk);
    compared++; if (la1_data_out !== 32'd0) begin mismatched++; $display("FAIL reset_la1: got %h expected 0", la1_data_out); end
    compared++; if (la2_data_out !== 32'd0) begin mismatched++; $display("FAIL reset_la2: got %h expected 0", la2_data_out); end
    compared++; if (la3_data_out !== 32'd0) begin mismatched++; $display("FAIL reset_la3: got %h expected 0", la3_data_out); end
    compared++; if (io_out !== '0) begin mismatched++; $display("FAIL reset_io_out: got %h expected 0", io_out); end
    compared++; if (io_oeb !== oeb_all1) begin mismatched++; $display("FAIL reset_io_oeb: got %h expected %h", io_oeb, oeb_all1); end
    active = 1'b1; #1;
    compared++; if (io_oeb !== oeb_act) begin mismatched++; $display("FAIL reset_oeb_active: got %h expected %h", io_oeb, oeb_act); end
    compared++; if (la1_data_out !== 32'd0) begin mismatched++; $display("FAIL reset_sum: got %h expected 0", la1_data_out); end
    @(negedge clk); rst_n = 1'b1;
    model_chain = 1'b0; model_count = '0;
    $display("test_reset done");
  endtask

  task automatic test_add();
    logic [31:0] pa[6] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'hAAAA_AAAA, 32'h0};
    logic [31:0] pb[6] = '{32'h0000_0003, 32'h0000_0001, 32'h9ABC_DEF0, 32'h8000_0000, 32'h5555_5555, 32'h0};
    pa[5] = $urandom; pb[5] = $urandom;
    for (int k = 0; k < 6; k++) begin
      write_reg(ADDR_A, pa[k]);
      write_reg(ADDR_B, pb[k]);
      sb.push_back('{"sum", {6'd0, pa[k] + pb[k]}});
      e = sb.pop_front();
      compared++; if (la1_data_out !== e.val[31:0]) begin mismatched++; $display("FAIL %s: got %h expected %h", e.tag, la1_data_out, e.val[31:0]); end
      addr_v = ADDR_A; sb.push_back('{"readback_a", {6'd0, pa[k]}}); #1;
      e = sb.pop_front();
      compared++; if (la3_data_out !== e.val[31:0]) begin mismatched++; $display("FAIL %s: got %h expected %h", e.tag, la3_data_out, e.val[31:0]); end
      addr_v = ADDR_B; sb.push_back('{"readback_b", {6'd0, pb[k]}}); #1;
      e = sb.pop_front();
      compared++; if (la3_data_out !== e.val[31:0]) begin mismatched++; $display("FAIL %s: got %h expected %h", e.tag, la3_data_out, e.val[31:0]); end
      $display("add a=%h b=%h sum=%h", pa[k], pb[k], la1_data_out);
    end
    // Writes to unmapped addresses vanish and read back as zero.
    write_reg(3'd5, 32'hDEAD_BEEF);
    sb.push_back('{"readback_addr5", 38'd0}); #1;
    e = sb.pop_front();
    compared++; if (la3_data_out !== e.val[31:0]) begin mismatched++; $display("FAIL %s: got %h expected %h", e.tag, la3_data_out, e.val[31:0]); end
    // A held strobe loads once, on its rising edge only.
    @(negedge clk); addr_v = ADDR_A; la1_data_in = 32'h11; strobe_v = 1'b1;
    @(negedge clk); la1_data_in = 32'h22;
    @(negedge clk); strobe_v = 1'b0;
    sb.push_back('{"held_strobe", 38'h11}); #1;
    e = sb.pop_front();
    compared++; if (la3_data_out !== e.val[31:0]) begin mismatched++; $display("FAIL %s: got %h expected %h", e.tag, la3_data_out, e.val[31:0]); end
    write_reg(ADDR_A, 32'd0);
    write_reg(ADDR_B, 32'd0);
    $display("test_add done");
  endtask

  task automatic test_ring();
    write_reg(ADDR_RING, 32'h4000_0000);
    write_reg(ADDR_SSEL, 32'h4000_0000);
    addr_v = ADDR_RING; sb.push_back('{"readback_ring", 38'h4000_0000}); #1;
    e = sb.pop_front();
    compared++; if (la3_data_out !== e.val[31:0]) begin mismatched++; $display("FAIL %s: got %h expected %h", e.tag, la3_data_out, e.val[31:0]); end
    run_v = 1'b1;
    for (int k = 0; k < 10; k++) begin
      model_chain = ~model_chain; model_count++;
      sb.push_back('{"ring_chain", {37'd0, model_chain}});
      sb.push_back('{"ring_sum", model_chain ? 38'd0 : 38'h4000_0000});
      @(negedge clk);
      e = sb.pop_front();
      compared++; if (io_out[IO_CHAIN_BIT] !== e.val[0]) begin mismatched++; $display("FAIL %s: got %b expected %b cycle %0d", e.tag, io_out[IO_CHAIN_BIT], e.val[0], k); end
      e = sb.pop_front();
      compared++; if (la1_data_out !== e.val[31:0]) begin mismatched++; $display("FAIL %s: got %h expected %h", e.tag, la1_data_out, e.val[31:0]); end
      compared++; if (io_out[IO_RUN_BIT] !== 1'b1) begin mismatched++; $display("FAIL ring_run_pin: got %b expected 1", io_out[IO_RUN_BIT]); end
      $display("ring cycle %0d chain=%b", k, io_out[IO_CHAIN_BIT]);
    end
    run_v = 1'b0;
    sb.push_back('{"ring_count", HAS_CNT ? {6'd0, model_count} : 38'd0}); #1;
    e = sb.pop_front();
    compared++; if (la2_data_out !== e.val[31:0]) begin mismatched++; $display("FAIL %s: got %h expected %h", e.tag, la2_data_out, e.val[31:0]); end
    sb.push_back('{"ring_hold", {37'd0, model_chain}});
    @(negedge clk);
    e = sb.pop_front();
    compared++; if (io_out[IO_CHAIN_BIT] !== e.val[0]) begin mismatched++; $display("FAIL %s: got %b expected %b", e.tag, io_out[IO_CHAIN_BIT], e.val[0]); end
    $display("test_ring done");
  endtask

  task automatic test_ext();
    logic pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    write_reg(ADDR_RING, 32'd0);
    write_reg(ADDR_EXT, 32'd1);
    write_reg(ADDR_SSEL, 32'd1);
    run_v = 1'b1;
    for (int k = 0; k < 7; k++) begin
      ext_v = pat[k];
      if (pat[k] != model_chain) model_count++;
      model_chain = pat[k];
      sb.push_back('{"ext_sum", {37'd0, pat[k]}});
      sb.push_back('{"ext_chain", {37'd0, pat[k]}});
      #1;
      e = sb.pop_front();
      compared++; if (la1_data_out !== e.val[31:0]) begin mismatched++; $display("FAIL %s: got %h expected %h", e.tag, la1_data_out, e.val[31:0]); end
      @(negedge clk);
      e = sb.pop_front();
      compared++; if (io_out[IO_CHAIN_BIT] !== e.val[0]) begin mismatched++; $display("FAIL %s: got %b expected %b step %0d", e.tag, io_out[IO_CHAIN_BIT], e.val[0], k); end
      $display("ext step %0d io9=%b chain=%b", k, pat[k], io_out[IO_CHAIN_BIT]);
    end
    run_v = 1'b0;
    sb.push_back('{"ext_count", HAS_CNT ? {6'd0, model_count} : 38'd0}); #1;
    e = sb.pop_front();
    compared++; if (la2_data_out !== e.val[31:0]) begin mismatched++; $display("FAIL %s: got %h expected %h", e.tag, la2_data_out, e.val[31:0]); end
    $display("test_ext done");
  endtask

  task automatic test_clear();
    // Clear while an increment is also due: clear must win.
    @(negedge clk);
    ext_v = ~model_chain; run_v = 1'b1; clr_v = 1'b1;
    model_chain = ext_v; model_count = '0;
    @(negedge clk);
    run_v = 1'b0; clr_v = 1'b0;
    sb.push_back('{"clear_count", 38'd0}); #1;
    e = sb.pop_front();
    compared++; if (la2_data_out !== e.val[31:0]) begin mismatched++; $display("FAIL %s: got %h expected %h", e.tag, la2_data_out, e.val[31:0]); end
    compared++; if (io_out[IO_CHAIN_BIT] !== model_chain) begin mismatched++; $display("FAIL clear_chain: got %b expected %b", io_out[IO_CHAIN_BIT], model_chain); end
    $display("test_clear count=%h", la2_data_out);
  endtask

  task automatic test_wrap();
    ext_v = 1'b0;
    write_reg(ADDR_EXT, 32'd0);
    write_reg(ADDR_RING, 32'h4000_0000);
    write_reg(ADDR_SSEL, 32'h4000_0000);
`ifdef EDGE_COUNTER_EN
    force dut.count_reg = 32'hFFFF_FFFE;
    #1;
    release dut.count_reg;
    model_count = 32'hFFFF_FFFE;
`endif
    run_v = 1'b1;
    for (int k = 0; k < 2; k++) begin
      model_chain = ~model_chain; model_count++;
      sb.push_back('{"wrap_count", HAS_CNT ? {6'd0, model_count} : 38'd0});
      @(negedge clk);
      e = sb.pop_front();
      compared++; if (la2_data_out !== e.val[31:0]) begin mismatched++; $display("FAIL %s: got %h expected %h", e.tag, la2_data_out, e.val[31:0]); end
      $display("wrap cycle %0d count=%h", k, la2_data_out);
    end
    run_v = 1'b0;
  endtask

  task automatic test_park();
    run_v = 1'b1; active = 1'b0;
    for (int k = 0; k < 3; k++) begin
      model_chain = ~model_chain; model_count++;
      @(negedge clk);
      compared++; if (io_out !== '0) begin mismatched++; $display("FAIL park_io_out: got %h expected 0", io_out); end
      compared++; if (la1_data_out !== 32'd0) begin mismatched++; $display("FAIL park_la1: got %h expected 0", la1_data_out); end
      compared++; if (io_oeb !== oeb_all1) begin mismatched++; $display("FAIL park_oeb: got %h expected %h", io_oeb, oeb_all1); end
    end
    run_v = 1'b0; active = 1'b1;
    sb.push_back('{"park_chain", {37'd0, model_chain}});
    sb.push_back('{"park_count", HAS_CNT ? {6'd0, model_count} : 38'd0});
    #1;
    e = sb.pop_front();
    compared++; if (io_out[IO_CHAIN_BIT] !== e.val[0]) begin mismatched++; $display("FAIL %s: got %b expected %b", e.tag, io_out[IO_CHAIN_BIT], e.val[0]); end
    e = sb.pop_front();
    compared++; if (la2_data_out !== e.val[31:0]) begin mismatched++; $display("FAIL %s: got %h expected %h", e.tag, la2_data_out, e.val[31:0]); end
    $display("test_park chain=%b count=%h", io_out[IO_CHAIN_BIT], la2_data_out);
  endtask

  task automatic test_reset_mid();
    write_reg(ADDR_A, 32'h0000_00F0);
    @(negedge clk);
    run_v = 1'b1; addr_v = ADDR_A; la1_data_in = 32'h0000_CAFE; strobe_v = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    compared++; if (la1_data_out !== 32'd0) begin mismatched++; $display("FAIL midreset_sum: got %h expected 0", la1_data_out); end
    compared++; if (la3_data_out !== 32'd0) begin mismatched++; $display("FAIL midreset_readback: got %h expected 0", la3_data_out); end
    compared++; if (la2_data_out !== 32'd0) begin mismatched++; $display("FAIL midreset_count: got %h expected 0", la2_data_out); end
    compared++; if (io_out[IO_CHAIN_BIT] !== 1'b0) begin mismatched++; $display("FAIL midreset_chain: got %b expected 0", io_out[IO_CHAIN_BIT]); end
    @(negedge clk);
    strobe_v = 1'b0; run_v = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    compared++; if (la3_data_out !== 32'd0) begin mismatched++; $display("FAIL midreset_no_write: got %h expected 0", la3_data_out); end
    $display("test_reset_mid done");
  endtask

  initial begin
    oeb_all1 = '1;
    oeb_act  = '1;
    oeb_act[IO_CHAIN_BIT] = 1'b0;
    oeb_act[IO_RUN_BIT]   = 1'b0;
    test_reset();
    test_add();
    test_ring();
    test_ext();
    test_clear();
    test_wrap();
    test_park();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
